enc_mpp_ssm_dist: RTL and testbench
===================================

Name: enc_mpp_ssm_dist

Overview:
- Encoder-side MPP (midpoint prediction) residual distributor; the transmit counterpart of the decoder MPP substream de-mux.
- Takes one block of quantized MPP residuals (3 components x 16 samples).
- Saturates each residual to the signed range of the current MPP bit width, then splits the block across the four substream packers (ssm0..ssm3), each with its own valid/ready handshake.
- Sits between the MPP quantizer and the substream multiplexer/balance FIFOs.

Parameters:
- W, 8, residual sample width in bits.
- N, 16, samples per component per block.
- CNT_W, 16, block counter width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- in_vld  in  1  block of residuals valid
- in_rdy  out  1  block accepted when in_vld & in_rdy
- mpp_bits  in  4  bits per MPP residual for this block; sampled on accept
- c0  in  N*W  component 0 residuals; sample i at [W*i+W-1:W*i], signed
- c1  in  N*W  component 1 residuals, same layout
- c2  in  N*W  component 2 residuals, same layout
- ssm0_vld/ssm1_vld/ssm2_vld/ssm3_vld  out  1 each  substream payload valid
- ssm0_rdy/ssm1_rdy/ssm2_rdy/ssm3_rdy  in  1 each  substream consumer ready
- ssm0_dat/ssm1_dat/ssm2_dat/ssm3_dat  out  12*W each  12 residuals; element j at [W*j+W-1:W*j]
- ssm0_bits/ssm1_bits/ssm2_bits/ssm3_bits  out  7 each  payload bit count = 12*b
- blkcounter  out  CNT_W  number of blocks accepted since reset

Behaviour:
- Reset (rstn=0 at posedge):
  - all ssmK_vld=0, all ssmK_dat=0, all ssmK_bits=0, blkcounter=0.
  - Internal pending flags cleared; in_rdy=1 from the first cycle after reset.
- Effective width b:
  - b = mpp_bits clamped to 1..8; 0 is treated as 1, values >8 are treated as 8.
- Saturation, per sample:
  - Range is [-2^(b-1), 2^(b-1)-1].
  - Values outside the range clip to the nearest bound; result is sign-extended to W.
  - b=8 is a passthrough.
- Mapping (decided layout):
  - ssm0 element j = c0[j] for j=0..3, c1[j-4] for j=4..7, c2[j-8] for j=8..11.
  - ssm1 element j = c0[j+4].
  - ssm2 element j = c1[j+4].
  - ssm3 element j = c2[j+4].
- Latency: accept at cycle T -> all four ssmK_vld=1 with data and bits at T+1.
- Per-substream handshake:
  - On accept, each ssmK_vld rises together with its pending flag.
  - pend_K clears and ssmK_vld drops on the cycle where ssmK_vld & ssmK_rdy.
  - ssmK_dat and ssmK_bits are held stable while ssmK_vld & !ssmK_rdy.
  - Substreams drain independently and in any order.
- in_rdy = ~(pend0|pend1|pend2|pend3), taken from registered flags (no combinational path from ssmK_rdy).
  - If the last drain and a new in_vld occur in the same cycle, the new block is accepted on the following cycle. This one-bubble behaviour is intended.
- blkcounter: +1 on each accept; wraps from 2^CNT_W-1 to 0.
- in_vld while in_rdy=0: no effect; upstream holds its data.
- Reset during a drain: pending data is discarded; no ssmK_vld after reset until a new accept.

Optional Feature:
- Macro MPP_DIST_DBUF_EN.
- When defined:
  - A second block slot (skid) is added behind the output registers.
  - in_rdy = second slot empty.
  - A block accepted while outputs are pending parks in the skid.
  - The skid advances into a substream's output register in the same cycle that substream handshakes, so data for that substream is back-to-back with no bubble.
  - Skid data for substreams not yet drained waits; per-substream order is preserved.
  - Saturation is applied on entry to the skid, using mpp_bits sampled at that accept.
- When undefined: single slot with the bubble behaviour described under Behaviour.

Test Plan:
- Mapping: c0[i]=i, c1[i]=16+i, c2[i]=32+i, mpp_bits=8, all rdy=1 -> at T+1:
  - ssm0 = {0,1,2,3,16,17,18,19,32,33,34,35}
  - ssm1 = 4..15; ssm2 = 20..31; ssm3 = 36..47
  - all ssmK_bits=96; blkcounter=1.
- Saturation, mpp_bits=3: inputs 5, -7, 3, -4 -> 3, -4, 3, -4.
  - mpp_bits=0: range is [-1,0], so input 2 -> 0 and -5 -> -1; ssmK_bits=12.
- Backpressure: ssm2_rdy=0 for 10 cycles, others rdy=1:
  - ssm0/1/3 drop vld at T+2; ssm2 data stays stable; in_rdy=0 until the cycle after ssm2 handshakes.
  - A second block is accepted exactly one cycle later.
- Counter wrap: preload by driving 65535 accepts -> blkcounter=65535; next accept -> 0.
- Reset mid-drain: rstn=0 for one cycle while ssm1 is pending -> all vld=0, in_rdy=1, blkcounter=0 the next cycle.
- MPP_DIST_DBUF_EN: in_vld held high, all rdy=1 -> in_rdy stays 1 and one block is output per cycle (no bubble).
  - With ssm3_rdy=0, in_rdy drops after the second accept.

Source files
------------

// File: rtl/enc_mpp_ssm_dist.sv
// enc_mpp_ssm_dist: saturates a 3x16 MPP residual block to the block's bit width and splits it over four substream packers.
// Optional MPP_DIST_DBUF_EN adds a skid block slot so substreams can stream back-to-back without a bubble.
module enc_mpp_ssm_dist #(
   parameter int W     = 8,
   parameter int N     = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [3:0]       mpp_bits,
   input  logic [N*W-1:0]   c0,
   input  logic [N*W-1:0]   c1,
   input  logic [N*W-1:0]   c2,
   output logic             ssm0_vld,
   output logic             ssm1_vld,
   output logic             ssm2_vld,
   output logic             ssm3_vld,
   input  logic             ssm0_rdy,
   input  logic             ssm1_rdy,
   input  logic             ssm2_rdy,
   input  logic             ssm3_rdy,
   output logic [12*W-1:0]  ssm0_dat,
   output logic [12*W-1:0]  ssm1_dat,
   output logic [12*W-1:0]  ssm2_dat,
   output logic [12*W-1:0]  ssm3_dat,
   output logic [6:0]       ssm0_bits,
   output logic [6:0]       ssm1_bits,
   output logic [6:0]       ssm2_bits,
   output logic [6:0]       ssm3_bits,
   output logic [CNT_W-1:0] blkcounter
);
   localparam int DW = 12 * W;
   logic [3:0]       pend_q, rdy, fire;
   logic [DW-1:0]    dat_q [4];
   logic [6:0]       bits_q [4];
   logic [CNT_W-1:0] cnt_q;
   logic [DW-1:0]    sat_d [4];
   logic [3:0]       b;
   logic [6:0]       nbits;
   logic             acc;
`ifdef MPP_DIST_DBUF_EN
   logic [3:0]       skv_q;
   logic [DW-1:0]    skd_q [4];
   logic [6:0]       skb_q;
`endif

   function automatic logic [W-1:0] sat(input logic [W-1:0] x, input logic [3:0] bb);
      int v, hi;
      v  = $signed(x);
      hi = (1 << (bb - 4'd1)) - 1;
      return (v > hi) ? W'(hi) : (v < -hi - 1) ? W'(-hi - 1) : x;
   endfunction

   assign b     = (mpp_bits == 4'd0) ? 4'd1 : (mpp_bits > 4'd8) ? 4'd8 : mpp_bits;
   assign nbits = 7'(b) * 7'd12;
   assign rdy   = {ssm3_rdy, ssm2_rdy, ssm1_rdy, ssm0_rdy};
   assign fire  = pend_q & rdy;
   assign acc   = in_vld & in_rdy;
`ifdef MPP_DIST_DBUF_EN
   assign in_rdy = ~|skv_q;
`else
   assign in_rdy = ~|pend_q;
`endif

   // ssm0 carries the first four samples of every component; ssm1..3 the tail of c0..c2
   always_comb begin
      for (int k = 0; k < 4; k++) sat_d[k] = '0;
      for (int j = 0; j < 4; j++) begin
         sat_d[0][W*j +: W]     = sat(c0[W*j +: W], b);
         sat_d[0][W*(j+4) +: W] = sat(c1[W*j +: W], b);
         sat_d[0][W*(j+8) +: W] = sat(c2[W*j +: W], b);
      end
      for (int j = 0; j < 12; j++) begin
         sat_d[1][W*j +: W] = sat(c0[W*(j+4) +: W], b);
         sat_d[2][W*j +: W] = sat(c1[W*(j+4) +: W], b);
         sat_d[3][W*j +: W] = sat(c2[W*(j+4) +: W], b);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pend_q <= '0;
         cnt_q  <= '0;
         for (int k = 0; k < 4; k++) begin
            dat_q[k]  <= '0;
            bits_q[k] <= '0;
         end
`ifdef MPP_DIST_DBUF_EN
         skv_q <= '0;
         skb_q <= '0;
         for (int k = 0; k < 4; k++) skd_q[k] <= '0;
`endif
      end else begin
         if (acc) cnt_q <= cnt_q + CNT_W'(1);
         for (int k = 0; k < 4; k++) begin
`ifdef MPP_DIST_DBUF_EN
            // a free output register takes the skid first, so per-substream order holds
            if (!pend_q[k] || fire[k]) begin
               if (skv_q[k]) begin
                  dat_q[k]  <= skd_q[k];
                  bits_q[k] <= skb_q;
                  skv_q[k]  <= 1'b0;
                  pend_q[k] <= 1'b1;
               end else if (acc) begin
                  dat_q[k]  <= sat_d[k];
                  bits_q[k] <= nbits;
                  pend_q[k] <= 1'b1;
               end else begin
                  pend_q[k] <= 1'b0;
               end
            end else if (acc) begin
               skd_q[k] <= sat_d[k];
               skb_q    <= nbits;
               skv_q[k] <= 1'b1;
            end
`else
            if (acc) begin
               dat_q[k]  <= sat_d[k];
               bits_q[k] <= nbits;
               pend_q[k] <= 1'b1;
            end else if (fire[k]) begin
               pend_q[k] <= 1'b0;
            end
`endif
         end
      end
   end

   assign {ssm3_vld, ssm2_vld, ssm1_vld, ssm0_vld} = pend_q;
   assign ssm0_dat   = dat_q[0];
   assign ssm1_dat   = dat_q[1];
   assign ssm2_dat   = dat_q[2];
   assign ssm3_dat   = dat_q[3];
   assign ssm0_bits  = bits_q[0];
   assign ssm1_bits  = bits_q[1];
   assign ssm2_bits  = bits_q[2];
   assign ssm3_bits  = bits_q[3];
   assign blkcounter = cnt_q;
endmodule

// File: tb/tb_enc_mpp_ssm_dist.sv
// tb_enc_mpp_ssm_dist: scoreboard bench for the MPP residual distributor.
// Counter width is reduced so the wrap scenario stays short.
module tb_enc_mpp_ssm_dist;
   localparam int W = 8, N = 16, CW = 10, DW = 12 * W;
   logic clk = 0, rstn = 0, in_vld = 0, in_rdy;
   logic [3:0] mpp_bits = 0, rdy = 4'hF, vld;
   logic [N*W-1:0] c0 = 0, c1 = 0, c2 = 0;
   logic [DW-1:0] dat [4];
   logic [6:0] bits [4];
   logic [CW-1:0] blkcounter;
   logic [DW+6:0] sbq [4][$];
   logic [DW+6:0] mon_e;
   int checks = 0, failures = 0, exp_cnt = 0;

   enc_mpp_ssm_dist #(.W(W), .N(N), .CNT_W(CW)) dut (
      .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_rdy(in_rdy), .mpp_bits(mpp_bits),
      .c0(c0), .c1(c1), .c2(c2),
      .ssm0_vld(vld[0]), .ssm1_vld(vld[1]), .ssm2_vld(vld[2]), .ssm3_vld(vld[3]),
      .ssm0_rdy(rdy[0]), .ssm1_rdy(rdy[1]), .ssm2_rdy(rdy[2]), .ssm3_rdy(rdy[3]),
      .ssm0_dat(dat[0]), .ssm1_dat(dat[1]), .ssm2_dat(dat[2]), .ssm3_dat(dat[3]),
      .ssm0_bits(bits[0]), .ssm1_bits(bits[1]), .ssm2_bits(bits[2]), .ssm3_bits(bits[3]),
      .blkcounter(blkcounter)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

   function automatic int eff_b(input logic [3:0] m);
      return (m < 1) ? 1 : (m > 8) ? 8 : int'(m);
   endfunction

   function automatic logic [W-1:0] msat(input int v, input logic [3:0] m);
      int lo = -(2 ** (eff_b(m) - 1));
      int hi = -lo - 1;
      int r = (v < lo) ? lo : (v > hi) ? hi : v;
      return r[W-1:0];
   endfunction

   function automatic logic [DW-1:0] mexp(input int k, input logic [N*W-1:0] a, input logic [N*W-1:0] bb,
                                          input logic [N*W-1:0] c, input logic [3:0] m);
      logic [DW-1:0] r;
      logic [W-1:0] x;
      int comp, idx;
      for (int j = 0; j < 12; j++) begin
         comp = (k == 0) ? j / 4 : k - 1;
         idx  = (k == 0) ? j % 4 : j + 4;
         x = (comp == 0) ? a[W*idx +: W] : (comp == 1) ? bb[W*idx +: W] : c[W*idx +: W];
         r[W*j +: W] = msat(int'($signed(x)), m);
      end
      return r;
   endfunction

   function automatic logic [N*W-1:0] rnd();
      logic [N*W-1:0] r;
      for (int i = 0; i < N * W / 32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   always @(negedge clk) begin
      #1;
      if (rstn)
         for (int k = 0; k < 4; k++)
            if (vld[k] && rdy[k]) begin
               checks++;
               if (sbq[k].size() == 0) begin
                  failures++;
                  $display("FAIL sb_ssm%0d unexpected payload got=%h required=none", k, dat[k]);
               end else begin
                  mon_e = sbq[k].pop_front();
                  if ({bits[k], dat[k]} !== mon_e) begin
                     failures++;
                     $display("FAIL sb_ssm%0d got=%h required=%h", k, {bits[k], dat[k]}, mon_e);
                  end
               end
            end
   end

   task automatic send(input logic [N*W-1:0] a, input logic [N*W-1:0] bb, input logic [N*W-1:0] c,
                       input logic [3:0] m, output int waits);
      c0 = a; c1 = bb; c2 = c; mpp_bits = m; in_vld = 1; waits = 0;
      while (!in_rdy && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      checks++;
      if (in_rdy !== 1'b1) begin
         failures++;
         $display("FAIL accept_timeout in_rdy=%b required=1", in_rdy);
         in_vld = 0;
         return;
      end
      for (int k = 0; k < 4; k++) sbq[k].push_back({7'(12 * eff_b(m)), mexp(k, a, bb, c, m)});
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      @(negedge clk);
      in_vld = 0;
   endtask

   task automatic drain();
      int t = 0;
      while ((vld !== 4'h0 || sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size() != 0) && t < 50) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (vld !== 4'h0 || sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size() != 0) begin
         failures++;
         $display("FAIL drain vld=%b required=0000 (scoreboard not empty)", vld);
      end
   endtask

   task automatic test_reset();
      rstn = 0;
      repeat (3) @(negedge clk);
      checks += 4;
      if (vld !== 4'h0) begin failures++; $display("FAIL reset_vld got=%b required=0000", vld); end
      if (blkcounter !== '0) begin failures++; $display("FAIL reset_cnt got=%0d required=0", blkcounter); end
      if ({dat[0], dat[1], dat[2], dat[3]} !== '0) begin failures++; $display("FAIL reset_dat got nonzero required=0"); end
      if ({bits[0], bits[1], bits[2], bits[3]} !== '0) begin failures++; $display("FAIL reset_bits got nonzero required=0"); end
      rstn = 1;
      @(negedge clk);
      checks++;
      if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_rdy got=%b required=1", in_rdy); end
   endtask

   task automatic test_mapping();
      logic [N*W-1:0] a, bb, c;
      int e0 [12] = '{0, 1, 2, 3, 16, 17, 18, 19, 32, 33, 34, 35};
      int w;
      for (int i = 0; i < N; i++) begin
         a[W*i +: W] = W'(i); bb[W*i +: W] = W'(16 + i); c[W*i +: W] = W'(32 + i);
      end
      rdy = 4'hF;
      send(a, bb, c, 4'd8, w);
      checks += 2;
      if (vld !== 4'hF) begin failures++; $display("FAIL map_vld got=%b required=1111", vld); end
      if (blkcounter !== CW'(1)) begin failures++; $display("FAIL map_cnt got=%0d required=1", blkcounter); end
      for (int j = 0; j < 12; j++) begin
         checks += 4;
         if (dat[0][W*j +: W] !== W'(e0[j])) begin failures++; $display("FAIL map_ssm0[%0d] got=%0d required=%0d", j, dat[0][W*j +: W], e0[j]); end
         if (dat[1][W*j +: W] !== W'(4 + j)) begin failures++; $display("FAIL map_ssm1[%0d] got=%0d required=%0d", j, dat[1][W*j +: W], 4 + j); end
         if (dat[2][W*j +: W] !== W'(20 + j)) begin failures++; $display("FAIL map_ssm2[%0d] got=%0d required=%0d", j, dat[2][W*j +: W], 20 + j); end
         if (dat[3][W*j +: W] !== W'(36 + j)) begin failures++; $display("FAIL map_ssm3[%0d] got=%0d required=%0d", j, dat[3][W*j +: W], 36 + j); end
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (bits[k] !== 7'd96) begin failures++; $display("FAIL map_bits%0d got=%0d required=96", k, bits[k]); end
      end
      drain();
   endtask

   task automatic test_saturation();
      logic [N*W-1:0] a;
      logic [W-1:0] ein [4] = '{8'sd5, -8'sd7, 8'sd3, -8'sd4};
      logic [W-1:0] eout [4] = '{8'sd3, -8'sd4, 8'sd3, -8'sd4};
      int w;
      a = '0;
      for (int i = 0; i < 4; i++) a[W*i +: W] = ein[i];
      send(a, rnd(), rnd(), 4'd3, w);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dat[0][W*i +: W] !== eout[i]) begin failures++; $display("FAIL sat3[%0d] got=%h required=%h", i, dat[0][W*i +: W], eout[i]); end
      end
      drain();
      a[W*0 +: W] = 8'sd2; a[W*1 +: W] = -8'sd5;
      send(a, rnd(), rnd(), 4'd0, w);
      checks += 3;
      if (dat[0][W-1:0] !== 8'h00) begin failures++; $display("FAIL sat0_pos got=%h required=00", dat[0][W-1:0]); end
      if (dat[0][2*W-1:W] !== 8'hFF) begin failures++; $display("FAIL sat0_neg got=%h required=ff", dat[0][2*W-1:W]); end
      if (bits[2] !== 7'd12) begin failures++; $display("FAIL sat0_bits got=%0d required=12", bits[2]); end
      drain();
      for (int n = 0; n < 24; n++) send(rnd(), rnd(), rnd(), 4'($urandom_range(0, 15)), w);
      drain();
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] d2;
      int w;
      rdy = 4'b1011;
      send(rnd(), rnd(), rnd(), 4'd8, w);
      d2 = dat[2];
      @(negedge clk);
      checks++;
      if (vld !== 4'b0100) begin failures++; $display("FAIL bp_vld got=%b required=0100", vld); end
      for (int i = 0; i < 9; i++) begin
         checks += 2;
         if (dat[2] !== d2) begin failures++; $display("FAIL bp_hold got=%h required=%h", dat[2], d2); end
`ifdef MPP_DIST_DBUF_EN
         if (in_rdy !== 1'b1) begin failures++; $display("FAIL bp_in_rdy got=%b required=1", in_rdy); end
`else
         if (in_rdy !== 1'b0) begin failures++; $display("FAIL bp_in_rdy got=%b required=0", in_rdy); end
`endif
         @(negedge clk);
      end
      rdy = 4'hF;
      send(rnd(), rnd(), rnd(), 4'd5, w);
      checks++;
`ifdef MPP_DIST_DBUF_EN
      if (w != 0) begin failures++; $display("FAIL bp_second_accept waits=%0d required=0", w); end
`else
      if (w != 1) begin failures++; $display("FAIL bp_second_accept waits=%0d required=1", w); end
`endif
      drain();
   endtask

   task automatic test_wrap();
      int w;
      rdy = 4'hF;
      while (exp_cnt != (1 << CW) - 1) send(rnd(), rnd(), rnd(), 4'd8, w);
      checks++;
      if (blkcounter !== CW'((1 << CW) - 1)) begin failures++; $display("FAIL wrap_max got=%0d required=%0d", blkcounter, (1 << CW) - 1); end
      send(rnd(), rnd(), rnd(), 4'd8, w);
      checks++;
      if (blkcounter !== '0) begin failures++; $display("FAIL wrap_zero got=%0d required=0", blkcounter); end
      drain();
   endtask

   task automatic test_reset_mid();
      int w;
      rdy = 4'b1101;
      send(rnd(), rnd(), rnd(), 4'd8, w);
      @(negedge clk);
      rstn = 0;
      for (int k = 0; k < 4; k++) sbq[k].delete();
      exp_cnt = 0;
      @(negedge clk);
      rstn = 1;
      checks += 4;
      if (vld !== 4'h0) begin failures++; $display("FAIL rst_mid_vld got=%b required=0000", vld); end
      if (in_rdy !== 1'b1) begin failures++; $display("FAIL rst_mid_in_rdy got=%b required=1", in_rdy); end
      if (blkcounter !== '0) begin failures++; $display("FAIL rst_mid_cnt got=%0d required=0", blkcounter); end
      if (dat[1] !== '0) begin failures++; $display("FAIL rst_mid_dat got=%h required=0", dat[1]); end
      rdy = 4'hF;
      repeat (2) @(negedge clk);
      checks++;
      if (vld !== 4'h0) begin failures++; $display("FAIL rst_mid_quiet got=%b required=0000", vld); end
   endtask

   task automatic test_back_to_back();
      int w, tot = 0;
      rdy = 4'hF;
      for (int n = 0; n < 6; n++) begin
         send(rnd(), rnd(), rnd(), 4'($urandom_range(0, 15)), w);
         tot += w;
      end
      checks++;
`ifdef MPP_DIST_DBUF_EN
      if (tot != 0) begin failures++; $display("FAIL b2b_bubbles got=%0d required=0", tot); end
`else
      if (tot != 5) begin failures++; $display("FAIL b2b_bubbles got=%0d required=5", tot); end
`endif
      drain();
      rdy = 4'b0111;
      send(rnd(), rnd(), rnd(), 4'd7, w);
`ifdef MPP_DIST_DBUF_EN
      send(rnd(), rnd(), rnd(), 4'd6, w);
      checks += 2;
      if (in_rdy !== 1'b0) begin failures++; $display("FAIL skid_full_in_rdy got=%b required=0", in_rdy); end
      if (vld !== 4'hF) begin failures++; $display("FAIL skid_vld got=%b required=1111", vld); end
`else
      @(negedge clk);
      checks += 2;
      if (in_rdy !== 1'b0) begin failures++; $display("FAIL ssm3_hold_in_rdy got=%b required=0", in_rdy); end
      if (vld !== 4'b1000) begin failures++; $display("FAIL ssm3_hold_vld got=%b required=1000", vld); end
`endif
      rdy = 4'hF;
      drain();
   endtask

   initial begin
      test_reset();
      test_mapping();
      test_saturation();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
